iq_scheduler: RTL and testbench



---
 rtl/iq_pkg.sv | 26 ++
 rtl/iq_scheduler_if.sv | 26 ++
 rtl/iq_age_select.sv | 43 ++++
 rtl/iq_scheduler.sv | 136 +++++++++++++
 tb/tb_iq_scheduler.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/iq_pkg.sv
// Shared parameters, entry-state encoding and helpers for the centralized
// issue-queue scheduler.
package iq_pkg;

   localparam int INSTR_NUM = 4;
   localparam int ISSUE_NUM = 4;
   localparam int CIQ_DEPTH = 16;
   localparam int ADDR_W    = 4;

   typedef enum logic [1:0] {
      FREE  = 2'd0,
      VALID = 2'd1,
      DRAIN = 2'd2
   } entry_state_e;

   typedef logic [ADDR_W-1:0] addr_t;

   function automatic logic [ADDR_W:0] popcnt(input logic [CIQ_DEPTH-1:0] v);
      logic [ADDR_W:0] cnt;
      cnt = '0;
      for (int i = 0; i < CIQ_DEPTH; i++)
         cnt = cnt + (ADDR_W+1)'(v[i]);
      return cnt;
   endfunction

endpackage

// File: rtl/iq_scheduler_if.sv
// Rename/wakeup/issue-port bundle seen by the issue-queue scheduler.
interface iq_scheduler_if;
   import iq_pkg::*;

   logic [INSTR_NUM-1:0]             alloc_req;
   logic                             alloc_stall;
   logic [INSTR_NUM-1:0][ADDR_W-1:0] free_addr;
   logic [INSTR_NUM-1:0]             free_valid;
   logic [CIQ_DEPTH-1:0]             entry_rdy;
   logic [ISSUE_NUM-1:0]             fu_busy;
   logic                             flush;
   logic [ISSUE_NUM-1:0][ADDR_W-1:0] arbit_addr;
   logic [ISSUE_NUM-1:0]             arbit_grant;
   logic [ADDR_W:0]                  occupancy;

   modport master (
      output alloc_req, entry_rdy, fu_busy, flush,
      input  alloc_stall, free_addr, free_valid, arbit_addr, arbit_grant, occupancy
   );

   modport slave (
      input  alloc_req, entry_rdy, fu_busy, flush,
      output alloc_stall, free_addr, free_valid, arbit_addr, arbit_grant, occupancy
   );

endinterface

// File: rtl/iq_age_select.sv
// Oldest-first select: ranks candidates by age and maps rank r to the r-th
// enabled port. Purely combinational; the age matrix is held by the parent.
module iq_age_select
   import iq_pkg::*;
(
   input  logic [CIQ_DEPTH-1:0][CIQ_DEPTH-1:0] older,
   input  logic [CIQ_DEPTH-1:0]                cand,
   input  logic [ISSUE_NUM-1:0]                port_en,
   output logic [ISSUE_NUM-1:0][CIQ_DEPTH-1:0] sel
);

   logic [CIQ_DEPTH-1:0][ADDR_W-1:0] rank;
   logic [ISSUE_NUM-1:0][ADDR_W-1:0] port_slot;
   logic [ADDR_W-1:0]                en_cnt;

   // rank[i] = number of candidates older than i; ages form a total order,
   // so candidate ranks are distinct and each port matches at most one.
   always_comb begin
      rank = '0;
      for (int i = 0; i < CIQ_DEPTH; i++)
         for (int j = 0; j < CIQ_DEPTH; j++)
            if (j != i && cand[j] && older[j][i])
               rank[i] = rank[i] + ADDR_W'(1);
   end

   always_comb begin
      en_cnt    = '0;
      port_slot = '0;
      for (int p = 0; p < ISSUE_NUM; p++) begin
         port_slot[p] = en_cnt;
         if (port_en[p])
            en_cnt = en_cnt + ADDR_W'(1);
      end
   end

   always_comb begin
      sel = '0;
      for (int p = 0; p < ISSUE_NUM; p++)
         for (int i = 0; i < CIQ_DEPTH; i++)
            sel[p][i] = port_en[p] & cand[i] & (rank[i] == port_slot[p]);
   end

endmodule

// File: rtl/iq_scheduler.sv
// Issue-queue allocation and oldest-first select: owns per-entry state and
// relative age; grants and occupancy are registered.
module iq_scheduler
   import iq_pkg::*;
(
   input logic           clk,
   input logic           rst,
   iq_scheduler_if.slave bus
);

   entry_state_e st     [CIQ_DEPTH];
   entry_state_e st_nxt [CIQ_DEPTH];

   logic [CIQ_DEPTH-1:0][CIQ_DEPTH-1:0] older, older_nxt, prior;
   logic [CIQ_DEPTH-1:0]                free_v, valid_v, avail, taken, alloc_v;
   logic [CIQ_DEPTH-1:0]                cand, issued, occ_nxt_v;
   logic [ADDR_W:0]                     n_free, n_req, occ_q;
   logic                                stall, found;
   logic [ISSUE_NUM-1:0][CIQ_DEPTH-1:0] sel;
   logic [ISSUE_NUM-1:0]                grant_nxt, grant_q;
   logic [ISSUE_NUM-1:0][ADDR_W-1:0]    addr_nxt, addr_q;

   always_comb begin
      free_v  = '0;
      valid_v = '0;
      for (int e = 0; e < CIQ_DEPTH; e++) begin
         free_v[e]  = (st[e] == FREE);
         valid_v[e] = (st[e] == VALID);
      end
   end

   // Allocation: requesting lanes in ascending order take the lowest FREE
   // slots. prior[e] records what a newly written entry must be younger than.
   always_comb begin
      n_free        = popcnt(free_v);
      n_req         = popcnt(CIQ_DEPTH'(bus.alloc_req));
      stall         = bus.flush | (n_free < n_req);
      avail         = free_v;
      taken         = ~free_v;
      alloc_v       = '0;
      prior         = '0;
      found         = 1'b0;
      bus.free_addr = '0;
      for (int l = 0; l < INSTR_NUM; l++) begin
         found = 1'b0;
         if (bus.alloc_req[l]) begin
            for (int e = 0; e < CIQ_DEPTH; e++) begin
               if (!found && avail[e]) begin
                  found            = 1'b1;
                  avail[e]         = 1'b0;
                  bus.free_addr[l] = ADDR_W'(e);
                  if (!stall) begin
                     alloc_v[e] = 1'b1;
                     prior[e]   = taken;
                     taken[e]   = 1'b1;
                  end
               end
            end
         end
      end
      bus.alloc_stall = stall;
      bus.free_valid  = bus.alloc_req & {INSTR_NUM{~stall}};
   end

   always_comb begin
      older_nxt = older;
      for (int i = 0; i < CIQ_DEPTH; i++)
         for (int j = 0; j < CIQ_DEPTH; j++)
            if (i != j) begin
               if (alloc_v[j])
                  older_nxt[i][j] = prior[j][i];
               else if (alloc_v[i])
                  older_nxt[i][j] = ~prior[i][j];
            end
   end

   assign cand = valid_v & bus.entry_rdy;

   iq_age_select u_age_select (
      .older   (older),
      .cand    (cand),
      .port_en (~bus.fu_busy),
      .sel     (sel)
   );

   always_comb begin
      issued    = '0;
      grant_nxt = '0;
      addr_nxt  = '0;
      for (int p = 0; p < ISSUE_NUM; p++) begin
         grant_nxt[p] = |sel[p];
         issued       = issued | sel[p];
         for (int i = 0; i < CIQ_DEPTH; i++)
            if (sel[p][i])
               addr_nxt[p] = ADDR_W'(i);
      end
   end

   // DRAIN always returns to FREE after one cycle, so a slot is never
   // offered for allocation while the queue is still reading it out.
   always_comb begin
      occ_nxt_v = '0;
      for (int e = 0; e < CIQ_DEPTH; e++) begin
         st_nxt[e] = st[e];
         unique case (st[e])
            FREE:    if (alloc_v[e]) st_nxt[e] = VALID;
            VALID:   if (issued[e])  st_nxt[e] = DRAIN;
            DRAIN:   st_nxt[e] = FREE;
            default: st_nxt[e] = FREE;
         endcase
         occ_nxt_v[e] = (st_nxt[e] != FREE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         for (int e = 0; e < CIQ_DEPTH; e++)
            st[e] <= FREE;
         grant_q <= '0;
         addr_q  <= '0;
         occ_q   <= '0;
      end else begin
         for (int e = 0; e < CIQ_DEPTH; e++)
            st[e] <= st_nxt[e];
         older   <= older_nxt;
         grant_q <= grant_nxt;
         addr_q  <= addr_nxt;
         occ_q   <= popcnt(occ_nxt_v);
      end
   end

   assign bus.arbit_grant = grant_q;
   assign bus.arbit_addr  = addr_q;
   assign bus.occupancy   = occ_q;

endmodule

// File: tb/tb_iq_scheduler.sv
// Directed checks of allocation, oldest-first select, drain timing and flush.
module tb_iq_scheduler;
   import iq_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   ord [3] = '{7, 2, 9};

   iq_scheduler_if bus ();

   iq_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.alloc_req = '0;
      bus.entry_rdy = '0;
      bus.fu_busy   = '0;
      bus.flush     = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic fill(input int n);
      int rem, k;
      rem = n;
      while (rem > 0) begin
         k = (rem > 4) ? 4 : rem;
         bus.alloc_req = 4'((1 << k) - 1);
         tick();
         rem -= k;
      end
      bus.alloc_req = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state and first allocate/grant round
      do_reset();
      #1;
      chk("rst_grant", 32'(bus.arbit_grant), 32'h0);
      chk("rst_addr",  32'(bus.arbit_addr),  32'h0);
      chk("rst_occ",   32'(bus.occupancy),   32'd0);
      chk("rst_stall", 32'(bus.alloc_stall), 32'd0);
      bus.alloc_req = 4'hf;
      bus.entry_rdy = '1;
      #1;
      chk("t1_free_addr",  32'(bus.free_addr),  32'h3210);
      chk("t1_free_valid", 32'(bus.free_valid), 32'hf);
      tick();
      bus.alloc_req = '0;
      #1;
      chk("t1_occ",         32'(bus.occupancy),   32'd4);
      chk("t1_grant_early", 32'(bus.arbit_grant), 32'h0);
      tick();
      chk("t1_grant", 32'(bus.arbit_grant), 32'hf);
      chk("t1_addr",  32'(bus.arbit_addr),  32'h3210);
      chk("t1_occ_drain", 32'(bus.occupancy), 32'd4);
      tick();
      chk("t1_occ_free",  32'(bus.occupancy),   32'd0);
      chk("t1_grant_end", 32'(bus.arbit_grant), 32'h0);

      // Full queue, busy ports 0 and 2
      do_reset();
      fill(16);
      #1;
      chk("t2_occ", 32'(bus.occupancy), 32'd16);
      bus.alloc_req = 4'b0001;
      #1;
      chk("t2_full_stall", 32'(bus.alloc_stall), 32'd1);
      chk("t2_full_fv",    32'(bus.free_valid),  32'h0);
      bus.alloc_req = '0;
      bus.entry_rdy = '1;
      bus.fu_busy   = 4'b0101;
      tick();
      bus.entry_rdy = '0;
      bus.fu_busy   = '0;
      chk("t2_grant", 32'(bus.arbit_grant), 32'b1010);
      chk("t2_addr",  32'(bus.arbit_addr),  32'h1000);
      chk("t2_occ_drain", 32'(bus.occupancy), 32'd16);
      tick();
      chk("t2_occ_14", 32'(bus.occupancy), 32'd14);

      // Two free slots: three requests stall, two fit
      bus.alloc_req = 4'b0111;
      #1;
      chk("t3_stall", 32'(bus.alloc_stall), 32'd1);
      chk("t3_fv",    32'(bus.free_valid),  32'h0);
      tick();
      bus.alloc_req = '0;
      #1;
      chk("t3_occ_hold", 32'(bus.occupancy), 32'd14);
      bus.alloc_req = 4'b0011;
      #1;
      chk("t3_fit_stall", 32'(bus.alloc_stall), 32'd0);
      chk("t3_fit_fv",    32'(bus.free_valid),  32'h3);
      chk("t3_fit_addr",  32'(bus.free_addr),   32'h0010);
      tick();
      bus.alloc_req = '0;
      chk("t3_occ_16", 32'(bus.occupancy), 32'd16);

      // Drained slot is withheld for one cycle, then reused
      do_reset();
      fill(8);
      bus.entry_rdy = 16'h0020;
      tick();
      bus.entry_rdy = '0;
      bus.alloc_req = 4'b0001;
      #1;
      chk("t4_grant",      32'(bus.arbit_grant), 32'h1);
      chk("t4_addr",       32'(bus.arbit_addr),  32'h5);
      chk("t4_free_drain", 32'(bus.free_addr),   32'h8);
      tick();
      chk("t4_free_reuse", 32'(bus.free_addr),   32'h5);
      tick();
      bus.alloc_req = '0;

      // Age order follows allocation order, not index
      do_reset();
      fill(16);
      for (int k = 0; k < 3; k++) begin
         bus.entry_rdy = 16'(1) << ord[k];
         tick();
         bus.entry_rdy = '0;
         tick();
         bus.alloc_req = 4'b0001;
         #1;
         chk("t5_realloc", 32'(bus.free_addr), 32'(ord[k]));
         tick();
         bus.alloc_req = '0;
      end
      bus.entry_rdy = 16'h0284;
      tick();
      bus.entry_rdy = '0;
      chk("t5_grant", 32'(bus.arbit_grant), 32'b0111);
      chk("t5_addr",  32'(bus.arbit_addr),  32'h0927);

      // Flush with allocation and ready entries pending
      do_reset();
      fill(10);
      #1;
      chk("t6_occ", 32'(bus.occupancy), 32'd10);
      bus.flush     = 1'b1;
      bus.alloc_req = 4'hf;
      bus.entry_rdy = '1;
      #1;
      chk("t6_stall", 32'(bus.alloc_stall), 32'd1);
      chk("t6_fv",    32'(bus.free_valid),  32'h0);
      tick();
      bus.flush     = 1'b0;
      bus.alloc_req = '0;
      bus.entry_rdy = '0;
      chk("t6_occ_0", 32'(bus.occupancy),   32'd0);
      chk("t6_grant", 32'(bus.arbit_grant), 32'h0);
      chk("t6_addr",  32'(bus.arbit_addr),  32'h0);
      bus.alloc_req = 4'hf;
      #1;
      chk("t6_post_free", 32'(bus.free_addr), 32'h3210);
      bus.alloc_req = '0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
